// File: rtl/xvga_timing_gen.sv
// Raster timing generator: two run-time selectable video modes, pixel enable,
// end-of-line / start-of-frame pulses and a completed-frame counter.
//
// Ports:
//   vclock_in        video clock
//   reset_n_in       asynchronous active-low reset
//   pix_en_in        counters advance only when high
//   mode_in          requested mode, taken only at frame wrap
//   hcount_out       pixel index on the current line
//   vcount_out       line index in the current frame
//   hsync_out        active-high horizontal sync
//   vsync_out        active-high vertical sync
//   blank_out        high outside the active area
//   eol_out          one-cycle pulse when hcount_out first shows 0
//   sof_out          one-cycle pulse when the frame restarts at (0,0)
//   mode_out         mode currently in effect
//   frame_count_out  completed frames, modulo 2^FCW
module xvga_timing_gen #(
    parameter int unsigned HW     = 11,
    parameter int unsigned VW     = 10,
    parameter int unsigned FCW    = 8,
    parameter int unsigned H_ACT0 = 1024,
    parameter int unsigned H_FP0  = 24,
    parameter int unsigned H_SYN0 = 136,
    parameter int unsigned H_BP0  = 160,
    parameter int unsigned V_ACT0 = 768,
    parameter int unsigned V_FP0  = 3,
    parameter int unsigned V_SYN0 = 6,
    parameter int unsigned V_BP0  = 29,
    parameter int unsigned H_ACT1 = 640,
    parameter int unsigned H_FP1  = 16,
    parameter int unsigned H_SYN1 = 96,
    parameter int unsigned H_BP1  = 48,
    parameter int unsigned V_ACT1 = 480,
    parameter int unsigned V_FP1  = 10,
    parameter int unsigned V_SYN1 = 2,
    parameter int unsigned V_BP1  = 33
) (
    input  logic           vclock_in,
    input  logic           reset_n_in,
    input  logic           pix_en_in,
    input  logic           mode_in,
    output logic [HW-1:0]  hcount_out,
    output logic [VW-1:0]  vcount_out,
    output logic           hsync_out,
    output logic           vsync_out,
    output logic           blank_out,
    output logic           eol_out,
    output logic           sof_out,
    output logic           mode_out,
    output logic [FCW-1:0] frame_count_out
);

    // Constants are one bit wider than the counters so that a total of
    // exactly 2^HW (or 2^VW) still fits in the sync-end comparison.
    localparam logic [HW:0] H_LAST0 =
        (HW+1)'(H_ACT0 + H_FP0 + H_SYN0 + H_BP0 - 1);
    localparam logic [HW:0] H_LAST1 =
        (HW+1)'(H_ACT1 + H_FP1 + H_SYN1 + H_BP1 - 1);
    localparam logic [VW:0] V_LAST0 =
        (VW+1)'(V_ACT0 + V_FP0 + V_SYN0 + V_BP0 - 1);
    localparam logic [VW:0] V_LAST1 =
        (VW+1)'(V_ACT1 + V_FP1 + V_SYN1 + V_BP1 - 1);

    localparam logic [HW:0] H_SB0 = (HW+1)'(H_ACT0 + H_FP0);
    localparam logic [HW:0] H_SE0 = (HW+1)'(H_ACT0 + H_FP0 + H_SYN0);
    localparam logic [HW:0] H_SB1 = (HW+1)'(H_ACT1 + H_FP1);
    localparam logic [HW:0] H_SE1 = (HW+1)'(H_ACT1 + H_FP1 + H_SYN1);
    localparam logic [VW:0] V_SB0 = (VW+1)'(V_ACT0 + V_FP0);
    localparam logic [VW:0] V_SE0 = (VW+1)'(V_ACT0 + V_FP0 + V_SYN0);
    localparam logic [VW:0] V_SB1 = (VW+1)'(V_ACT1 + V_FP1);
    localparam logic [VW:0] V_SE1 = (VW+1)'(V_ACT1 + V_FP1 + V_SYN1);
    localparam logic [HW:0] H_AC0 = (HW+1)'(H_ACT0);
    localparam logic [HW:0] H_AC1 = (HW+1)'(H_ACT1);
    localparam logic [VW:0] V_AC0 = (VW+1)'(V_ACT0);
    localparam logic [VW:0] V_AC1 = (VW+1)'(V_ACT1);

    localparam logic [HW-1:0]  H_ONE = HW'(1);
    localparam logic [VW-1:0]  V_ONE = VW'(1);
    localparam logic [FCW-1:0] F_ONE = FCW'(1);

    logic [HW-1:0]  hcount_q, hcount_d;
    logic [VW-1:0]  vcount_q, vcount_d;
    logic [FCW-1:0] fc_q, fc_d;
    logic           mode_q, mode_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           blank_q, blank_d;
    logic           eol_q, eol_d;
    logic           sof_q, sof_d;

    logic [HW:0] h_last, h_ext, hs_beg, hs_end, h_act;
    logic [VW:0] v_last, v_ext, vs_beg, vs_end, v_act;
    logic        h_wrap, v_wrap, f_wrap;

    always_comb begin
        h_last = mode_q ? H_LAST1 : H_LAST0;
        v_last = mode_q ? V_LAST1 : V_LAST0;
        h_wrap = ({1'b0, hcount_q} == h_last);
        v_wrap = ({1'b0, vcount_q} == v_last);
        f_wrap = h_wrap && v_wrap;

        hcount_d = hcount_q;
        vcount_d = vcount_q;
        mode_d   = mode_q;
        fc_d     = fc_q;
        eol_d    = 1'b0;
        sof_d    = 1'b0;

        if (pix_en_in) begin
            eol_d = h_wrap;
            sof_d = f_wrap;
            if (h_wrap) begin
                hcount_d = '0;
                if (v_wrap) begin
                    vcount_d = '0;
                end else begin
                    vcount_d = vcount_q + V_ONE;
                end
            end else begin
                hcount_d = hcount_q + H_ONE;
            end
            if (f_wrap) begin
                mode_d = mode_in;
                fc_d   = fc_q + F_ONE;
            end
        end

        // Decode the next counts with the next mode so that sync and blank
        // leave the flops aligned with the counts they describe.
        h_ext  = {1'b0, hcount_d};
        v_ext  = {1'b0, vcount_d};
        hs_beg = mode_d ? H_SB1 : H_SB0;
        hs_end = mode_d ? H_SE1 : H_SE0;
        vs_beg = mode_d ? V_SB1 : V_SB0;
        vs_end = mode_d ? V_SE1 : V_SE0;
        h_act  = mode_d ? H_AC1 : H_AC0;
        v_act  = mode_d ? V_AC1 : V_AC0;

        hsync_d = (h_ext >= hs_beg) && (h_ext < hs_end);
        vsync_d = (v_ext >= vs_beg) && (v_ext < vs_end);
        blank_d = (h_ext >= h_act) || (v_ext >= v_act);
    end

    always_ff @(posedge vclock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            hcount_q <= '0;
            vcount_q <= '0;
            mode_q   <= 1'b0;
            fc_q     <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            blank_q  <= 1'b0;
            eol_q    <= 1'b0;
            sof_q    <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            mode_q   <= mode_d;
            fc_q     <= fc_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
            eol_q    <= eol_d;
            sof_q    <= sof_d;
        end
    end

    assign hcount_out      = hcount_q;
    assign vcount_out      = vcount_q;
    assign hsync_out       = hsync_q;
    assign vsync_out       = vsync_q;
    assign blank_out       = blank_q;
    assign eol_out         = eol_q;
    assign sof_out         = sof_q;
    assign mode_out        = mode_q;
    assign frame_count_out = fc_q;

endmodule
